// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: datapath widths and JumpIn encodings.
package mips_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    localparam logic [1:0] JUMP_NONE = 2'b00;
    localparam logic [1:0] JUMP_J    = 2'b01;
    localparam logic [1:0] JUMP_JAL  = 2'b10;
    localparam logic [1:0] JUMP_JR   = 2'b11;

endpackage

// File: rtl/data_memory.sv
// Word-organised data memory: byte-enable synchronous write, asynchronous read.
module data_memory
    import mips_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned ADDR_W    = 10
) (
    input  logic              clk_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [3:0]        be_i,
    input  logic [XLEN-1:0]   wdata_i,
    output logic [XLEN-1:0]   rdata_o
);

    // No reset: contents deliberately survive a pipeline reset.
    logic [XLEN-1:0] mem_q [MEM_WORDS];

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < 4; k++) begin
            if (be_i[k]) begin
                mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: branch resolution, sized loads/stores, and the MEM/WB register.
module mem_stage
    import mips_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned ADDR_W    = 10
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             BranchIn,
    input  logic             NotZeroIn,
    input  logic             ZeroIn,
    input  logic [XLEN-1:0]  BranchTargetAddressIn,
    input  logic             MemReadIn,
    input  logic             MemWriteIn,
    input  logic             LoadStoreByteIn,
    input  logic             LoadStoreHalfIn,
    input  logic             RegWriteIn,
    input  logic             MemToRegIn,
    input  logic [1:0]       JumpIn,
    input  logic [XLEN-1:0]  ALUIn,
    input  logic [XLEN-1:0]  MemoryWriteDataIn,
    input  logic [REG_W-1:0] DestinationRegIn,
    input  logic [XLEN-1:0]  PCValueForJALIn,
    output logic             PCSrcOut,
    output logic [XLEN-1:0]  BranchPCOut,
    output logic             RegWriteOut,
    output logic             MemToRegOut,
    output logic             LinkOut,
    output logic [XLEN-1:0]  MemDataOut,
    output logic [XLEN-1:0]  ALUOut,
    output logic [REG_W-1:0] DestinationRegOut,
    output logic [XLEN-1:0]  PCValueForJALOut
);

    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        lane;
    logic [3:0]        byte_en;
    logic [XLEN-1:0]   wr_data;
    logic [XLEN-1:0]   rd_word;
    logic [7:0]        byte_val;
    logic [15:0]       half_val;
    logic [XLEN-1:0]   load_data;

    logic             reg_write_d, reg_write_q;
    logic             mem_to_reg_d, mem_to_reg_q;
    logic             link_d, link_q;
    logic [XLEN-1:0]  mem_data_d, mem_data_q;
    logic [XLEN-1:0]  alu_d, alu_q;
    logic [REG_W-1:0] dest_reg_d, dest_reg_q;
    logic [XLEN-1:0]  pc_jal_d, pc_jal_q;

    // Upper address bits are dropped so accesses wrap modulo MEM_WORDS.
    assign word_idx = ALUIn[ADDR_W+1:2];
    assign lane     = ALUIn[1:0];

    assign PCSrcOut    = ~Rst & BranchIn & (NotZeroIn ? ~ZeroIn : ZeroIn);
    assign BranchPCOut = BranchTargetAddressIn;

    // Store lanes: byte wins over half; data is replicated so any lane sees it.
    always_comb begin
        byte_en = 4'b1111;
        wr_data = MemoryWriteDataIn;
        if (LoadStoreByteIn) begin
            byte_en = 4'b0001 << lane;
            wr_data = {4{MemoryWriteDataIn[7:0]}};
        end else if (LoadStoreHalfIn) begin
            byte_en = lane[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{MemoryWriteDataIn[15:0]}};
        end
        if (!MemWriteIn || Rst) begin
            byte_en = 4'b0000;
        end
    end

    data_memory #(
        .MEM_WORDS (MEM_WORDS),
        .ADDR_W    (ADDR_W)
    ) u_data_memory (
        .clk_i   (Clk),
        .addr_i  (word_idx),
        .be_i    (byte_en),
        .wdata_i (wr_data),
        .rdata_o (rd_word)
    );

    always_comb begin
        byte_val  = rd_word[{lane, 3'b000} +: 8];
        half_val  = rd_word[{lane[1], 4'b0000} +: 16];
        load_data = rd_word;
        if (LoadStoreByteIn) begin
            load_data = {{24{byte_val[7]}}, byte_val};
        end else if (LoadStoreHalfIn) begin
            load_data = {{16{half_val[15]}}, half_val};
        end
    end

    always_comb begin
        reg_write_d  = RegWriteIn;
        mem_to_reg_d = MemToRegIn;
        link_d       = (JumpIn == JUMP_JAL);
        mem_data_d   = MemReadIn ? load_data : '0;
        alu_d        = ALUIn;
        dest_reg_d   = DestinationRegIn;
        pc_jal_d     = PCValueForJALIn;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            link_q       <= 1'b0;
            mem_data_q   <= '0;
            alu_q        <= '0;
            dest_reg_q   <= '0;
            pc_jal_q     <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            link_q       <= link_d;
            mem_data_q   <= mem_data_d;
            alu_q        <= alu_d;
            dest_reg_q   <= dest_reg_d;
            pc_jal_q     <= pc_jal_d;
        end
    end

    assign RegWriteOut       = reg_write_q;
    assign MemToRegOut       = mem_to_reg_q;
    assign LinkOut           = link_q;
    assign MemDataOut        = mem_data_q;
    assign ALUOut            = alu_q;
    assign DestinationRegOut = dest_reg_q;
    assign PCValueForJALOut  = pc_jal_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table plus reset corner-case sequences.
module tb_mem_stage;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        BranchIn = 1'b0, NotZeroIn = 1'b0, ZeroIn = 1'b0;
    logic [31:0] BranchTargetAddressIn = '0;
    logic        MemReadIn = 1'b0, MemWriteIn = 1'b0;
    logic        LoadStoreByteIn = 1'b0, LoadStoreHalfIn = 1'b0;
    logic        RegWriteIn = 1'b0, MemToRegIn = 1'b0;
    logic [1:0]  JumpIn = 2'b00;
    logic [31:0] ALUIn = '0, MemoryWriteDataIn = '0;
    logic [4:0]  DestinationRegIn = '0;
    logic [31:0] PCValueForJALIn = '0;
    logic        PCSrcOut, RegWriteOut, MemToRegOut, LinkOut;
    logic [31:0] BranchPCOut, MemDataOut, ALUOut, PCValueForJALOut;
    logic [4:0]  DestinationRegOut;

    int n_checks = 0;
    int n_pass   = 0;

    mem_stage #(
        .MEM_WORDS (1024),
        .ADDR_W    (10)
    ) dut (
        .Clk                   (Clk),
        .Rst                   (Rst),
        .BranchIn              (BranchIn),
        .NotZeroIn             (NotZeroIn),
        .ZeroIn                (ZeroIn),
        .BranchTargetAddressIn (BranchTargetAddressIn),
        .MemReadIn             (MemReadIn),
        .MemWriteIn            (MemWriteIn),
        .LoadStoreByteIn       (LoadStoreByteIn),
        .LoadStoreHalfIn       (LoadStoreHalfIn),
        .RegWriteIn            (RegWriteIn),
        .MemToRegIn            (MemToRegIn),
        .JumpIn                (JumpIn),
        .ALUIn                 (ALUIn),
        .MemoryWriteDataIn     (MemoryWriteDataIn),
        .DestinationRegIn      (DestinationRegIn),
        .PCValueForJALIn       (PCValueForJALIn),
        .PCSrcOut              (PCSrcOut),
        .BranchPCOut           (BranchPCOut),
        .RegWriteOut           (RegWriteOut),
        .MemToRegOut           (MemToRegOut),
        .LinkOut               (LinkOut),
        .MemDataOut            (MemDataOut),
        .ALUOut                (ALUOut),
        .DestinationRegOut     (DestinationRegOut),
        .PCValueForJALOut      (PCValueForJALOut)
    );

    always #5 Clk = ~Clk;

    // ctl = {rw, m2r, rd, wr, sb, sh}; br = {branch, notzero, zero}
    typedef struct {
        string       name;
        logic [5:0]  ctl;
        logic [2:0]  br;
        logic [1:0]  jmp;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  dst;
        logic [31:0] pcj;
        logic        e_pcsrc;
        logic [31:0] e_mem;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic [5:0] c, logic [2:0] b, logic [1:0] j,
                                logic [31:0] a, logic [31:0] w, logic [4:0] d,
                                logic [31:0] p, logic ep, logic [31:0] em);
        vec_t v;
        v.name = n; v.ctl = c; v.br = b; v.jmp = j; v.alu = a; v.wd = w;
        v.dst = d; v.pcj = p; v.e_pcsrc = ep; v.e_mem = em;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic drive(input vec_t v, input logic [31:0] target);
        {RegWriteIn, MemToRegIn, MemReadIn, MemWriteIn, LoadStoreByteIn, LoadStoreHalfIn} = v.ctl;
        {BranchIn, NotZeroIn, ZeroIn} = v.br;
        JumpIn = v.jmp;
        ALUIn = v.alu;
        MemoryWriteDataIn = v.wd;
        DestinationRegIn = v.dst;
        PCValueForJALIn = v.pcj;
        BranchTargetAddressIn = target;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ":pcsrc"}, {31'd0, PCSrcOut}, 32'd0);
        chk({tag, ":regwrite"}, {31'd0, RegWriteOut}, 32'd0);
        chk({tag, ":memtoreg"}, {31'd0, MemToRegOut}, 32'd0);
        chk({tag, ":link"}, {31'd0, LinkOut}, 32'd0);
        chk({tag, ":memdata"}, MemDataOut, 32'd0);
        chk({tag, ":alu"}, ALUOut, 32'd0);
        chk({tag, ":dest"}, {27'd0, DestinationRegOut}, 32'd0);
        chk({tag, ":pcjal"}, PCValueForJALOut, 32'd0);
    endtask

    initial begin
        vec_t v;
        logic [31:0] tgt;

        vecs.push_back(mk("sw_dead",   6'b000100, 3'b000, 2'd0, 32'h10, 32'hDEADBEEF, 5'd0, 0, 0, 0));
        vecs.push_back(mk("lw_dead",   6'b111000, 3'b000, 2'd0, 32'h10, 32'h0, 5'd4, 0, 0, 32'hDEADBEEF));
        vecs.push_back(mk("sw_clr10",  6'b000100, 3'b000, 2'd0, 32'h10, 32'h0, 5'd0, 0, 0, 0));
        vecs.push_back(mk("sb_80",     6'b000110, 3'b000, 2'd0, 32'h13, 32'h12345680, 5'd0, 0, 0, 0));
        vecs.push_back(mk("lb_13",     6'b111010, 3'b000, 2'd0, 32'h13, 32'h0, 5'd5, 0, 0, 32'hFFFFFF80));
        vecs.push_back(mk("lw_10",     6'b111000, 3'b000, 2'd0, 32'h10, 32'h0, 5'd6, 0, 0, 32'h80000000));
        vecs.push_back(mk("lb_12",     6'b111010, 3'b000, 2'd0, 32'h12, 32'h0, 5'd6, 0, 0, 32'h0));
        vecs.push_back(mk("sw_clr20",  6'b000100, 3'b000, 2'd0, 32'h20, 32'h0, 5'd0, 0, 0, 0));
        vecs.push_back(mk("sh_22",     6'b000101, 3'b000, 2'd0, 32'h22, 32'hABCD7FFE, 5'd0, 0, 0, 0));
        vecs.push_back(mk("lw_20a",    6'b111000, 3'b000, 2'd0, 32'h20, 32'h0, 5'd7, 0, 0, 32'h7FFE0000));
        vecs.push_back(mk("lh_22",     6'b111001, 3'b000, 2'd0, 32'h22, 32'h0, 5'd7, 0, 0, 32'h00007FFE));
        vecs.push_back(mk("sw_clr20b", 6'b000100, 3'b000, 2'd0, 32'h20, 32'h0, 5'd0, 0, 0, 0));
        vecs.push_back(mk("sh_23",     6'b000101, 3'b000, 2'd0, 32'h23, 32'hABCD7FFE, 5'd0, 0, 0, 0));
        vecs.push_back(mk("lw_20b",    6'b111000, 3'b000, 2'd0, 32'h20, 32'h0, 5'd8, 0, 0, 32'h7FFE0000));
        vecs.push_back(mk("sh_20",     6'b000101, 3'b000, 2'd0, 32'h20, 32'h5555_8001, 5'd0, 0, 0, 0));
        vecs.push_back(mk("lh_21",     6'b111001, 3'b000, 2'd0, 32'h21, 32'h0, 5'd9, 0, 0, 32'hFFFF8001));
        vecs.push_back(mk("lw_21",     6'b111000, 3'b000, 2'd0, 32'h21, 32'h0, 5'd9, 0, 0, 32'h7FFE8001));
        vecs.push_back(mk("lw_wrap",   6'b111000, 3'b000, 2'd0, 32'h1010, 32'h0, 5'd9, 0, 0, 32'h80000000));
        vecs.push_back(mk("sb_prio",   6'b000111, 3'b000, 2'd0, 32'h11, 32'hAAAA1255, 5'd0, 0, 0, 0));
        vecs.push_back(mk("lw_prio",   6'b111000, 3'b000, 2'd0, 32'h10, 32'h0, 5'd10, 0, 0, 32'h80005500));
        vecs.push_back(mk("lb_prio",   6'b111011, 3'b000, 2'd0, 32'h11, 32'h0, 5'd10, 0, 0, 32'h55));
        vecs.push_back(mk("beq_take",  6'b000000, 3'b101, 2'd0, 32'h0, 32'h0, 5'd0, 0, 1, 0));
        vecs.push_back(mk("bne_not",   6'b000000, 3'b111, 2'd0, 32'h0, 32'h0, 5'd0, 0, 0, 0));
        vecs.push_back(mk("bne_take",  6'b000000, 3'b110, 2'd0, 32'h0, 32'h0, 5'd0, 0, 1, 0));
        vecs.push_back(mk("beq_not",   6'b000000, 3'b100, 2'd0, 32'h0, 32'h0, 5'd0, 0, 0, 0));
        vecs.push_back(mk("nobranch",  6'b000000, 3'b001, 2'd0, 32'h0, 32'h0, 5'd0, 0, 0, 0));
        vecs.push_back(mk("jal",       6'b100000, 3'b000, 2'd2, 32'h0, 32'h0, 5'd31, 32'h408, 0, 0));
        vecs.push_back(mk("jr",        6'b000000, 3'b000, 2'd3, 32'h44, 32'h0, 5'd0, 32'h99, 0, 0));
        vecs.push_back(mk("j",         6'b000000, 3'b000, 2'd1, 32'h0, 32'h0, 5'd0, 32'h77, 0, 0));

        // Reset state
        #1;
        chk_all_zero("reset");
        @(negedge Clk);
        Rst = 1'b0;

        foreach (vecs[i]) begin
            v = vecs[i];
            tgt = 32'h0040_0000 + 32'(i * 4);
            @(negedge Clk);
            drive(v, tgt);
            #1;
            chk({v.name, ":pcsrc"}, {31'd0, PCSrcOut}, {31'd0, v.e_pcsrc});
            chk({v.name, ":branchpc"}, BranchPCOut, tgt);
            @(posedge Clk);
            #1;
            chk({v.name, ":memdata"}, MemDataOut, v.e_mem);
            chk({v.name, ":regwrite"}, {31'd0, RegWriteOut}, {31'd0, v.ctl[5]});
            chk({v.name, ":memtoreg"}, {31'd0, MemToRegOut}, {31'd0, v.ctl[4]});
            chk({v.name, ":link"}, {31'd0, LinkOut}, {31'd0, v.jmp == 2'b10});
            chk({v.name, ":alu"}, ALUOut, v.alu);
            chk({v.name, ":dest"}, {27'd0, DestinationRegOut}, {27'd0, v.dst});
            chk({v.name, ":pcjal"}, PCValueForJALOut, v.pcj);
        end

        // Load non-zero state into MEM/WB so an async clear is observable
        @(negedge Clk);
        drive(mk("pre_rst", 6'b111000, 3'b000, 2'd2, 32'h10, 32'h0, 5'd7, 32'h1234, 0, 0), 32'h0);
        @(posedge Clk);
        #1;
        chk("pre_rst:memdata", MemDataOut, 32'h80005500);
        chk("pre_rst:link", {31'd0, LinkOut}, 32'd1);

        // Store in flight when reset hits mid-cycle
        @(negedge Clk);
        drive(mk("rst_sw", 6'b110100, 3'b101, 2'd2, 32'h10, 32'h11111111, 5'd3, 32'h50, 0, 0),
              32'hCAFE0000);
        #1;
        chk("rst_sw:pcsrc_before", {31'd0, PCSrcOut}, 32'd1);
        #1;
        Rst = 1'b1;
        #1;
        chk_all_zero("rst_async");
        @(posedge Clk);
        #1;
        chk_all_zero("rst_held");
        @(negedge Clk);
        Rst = 1'b0;
        drive(mk("post_rst", 6'b111000, 3'b000, 2'd0, 32'h10, 32'h0, 5'd2, 0, 0, 0), 32'h0);
        #1;
        chk("post_rst:regwrite_before_edge", {31'd0, RegWriteOut}, 32'd0);
        chk("post_rst:memdata_before_edge", MemDataOut, 32'd0);
        @(posedge Clk);
        #1;
        chk("post_rst:memdata_unchanged", MemDataOut, 32'h80005500);
        chk("post_rst:regwrite", {31'd0, RegWriteOut}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
